// File: rtl/scg_pkg.sv
// Shared definitions for the scg_* SDRAM command sequence generators:
// command encodings, mode-register bit positions and config legality.
package scg_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_PRE = 4'd5,
        CMD_MRS = 4'd7
    } scg_cmd_e;

    localparam int unsigned MR_BL_LSB   = 0;
    localparam int unsigned MR_BL_W     = 3;
    localparam int unsigned MR_BT_BIT   = 3;
    localparam int unsigned MR_CL_LSB   = 4;
    localparam int unsigned MR_CL_W     = 3;
    localparam int unsigned MR_WB_BIT   = 9;
    localparam int unsigned A10_PRE_ALL = 10;

    // Burst length 0-3 or 7 (full page), CAS latency 2 or 3.
    function automatic logic mrs_cfg_legal(input logic [2:0] bl, input logic [2:0] cl);
        return (bl inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd7}) && (cl inside {3'd2, 3'd3});
    endfunction

endpackage

// File: rtl/scg_wait_cnt.sv
// Load-and-count-down timer; expired is high while the count sits at 1.
module scg_wait_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] r_cnt;

    // Saturates at zero so an idle counter never wraps.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign expired = (r_cnt == W'(1));

endmodule

// File: rtl/scg_mrs.sv
// Mode-register-set sequence generator: optional PRECHARGE ALL + tRP,
// then one MRS/EMRS + tMRD, then a done (or err) pulse.
module scg_mrs
    import scg_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned BA_W      = 2,
    parameter int unsigned T_RP      = 3,
    parameter int unsigned T_MRD     = 2,
    parameter bit          PRE_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [2:0]        burst_len,
    input  logic              burst_type,
    input  logic [2:0]        cas_lat,
    input  logic              wb_single,
    input  logic              ext_sel,
    input  logic [ADDR_W-1:0] ext_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        command,
    output logic [ADDR_W-1:0] addr,
    output logic [BA_W-1:0]   ba
);

    localparam int unsigned MAX_T = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int unsigned CNT_W = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_RP, S_MRS, S_WAIT_MRD, S_DONE, S_ERR
    } state_e;

    state_e            r_state;
    state_e            w_next;
    logic [2:0]        r_bl;
    logic              r_bt;
    logic [2:0]        r_cl;
    logic              r_wb;
    logic              r_ext;
    logic [ADDR_W-1:0] r_ext_val;

    scg_cmd_e          w_cmd;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_expired;

    scg_wait_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_bl      <= '0;
            r_bt      <= 1'b0;
            r_cl      <= '0;
            r_wb      <= 1'b0;
            r_ext     <= 1'b0;
            r_ext_val <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_bl      <= burst_len;
                r_bt      <= burst_type;
                r_cl      <= cas_lat;
                r_wb      <= wb_single;
                r_ext     <= ext_sel;
                r_ext_val <= ext_val;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cmd      = CMD_NOP;
        addr       = '0;
        ba         = '0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                // Legality is judged on the live inputs being captured this cycle.
                if (start) begin
                    if (!ext_sel && !mrs_cfg_legal(burst_len, cas_lat)) w_next = S_ERR;
                    else if (PRE_FIRST)                                  w_next = S_PRE;
                    else                                                 w_next = S_MRS;
                end
            end
            S_PRE: begin
                w_cmd             = CMD_PRE;
                addr[A10_PRE_ALL] = 1'b1;
                if (T_RP == 1) begin
                    w_next = S_MRS;
                end else begin
                    w_next     = S_WAIT_RP;
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_RP - 1);
                end
            end
            S_WAIT_RP: begin
                if (w_expired) w_next = S_MRS;
            end
            S_MRS: begin
                w_cmd = CMD_MRS;
                if (r_ext) begin
                    ba   = BA_W'(1);
                    addr = r_ext_val;
                end else begin
                    addr[MR_BL_LSB +: MR_BL_W] = r_bl;
                    addr[MR_BT_BIT]            = r_bt;
                    addr[MR_CL_LSB +: MR_CL_W] = r_cl;
                    addr[MR_WB_BIT]            = r_wb;
                end
                if (T_MRD == 1) begin
                    w_next = S_DONE;
                end else begin
                    w_next     = S_WAIT_MRD;
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_MRD - 1);
                end
            end
            S_WAIT_MRD: begin
                if (w_expired) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                done   = 1'b1;
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign command = w_cmd;

endmodule

// File: tb/tb_scg_mrs.sv
// Directed bench for scg_mrs: default-parameter instance plus a
// PRE_FIRST=0 / T_MRD=1 instance for the short EMRS path.
module tb_scg_mrs;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start, start2;
    logic [2:0]  burst_len;
    logic        burst_type;
    logic [2:0]  cas_lat;
    logic        wb_single;
    logic        ext_sel;
    logic [12:0] ext_val;

    logic        busy, done, err;
    logic [3:0]  command;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        busy2, done2, err2;
    logic [3:0]  command2;
    logic [12:0] addr2;
    logic [1:0]  ba2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    scg_mrs dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .burst_len(burst_len), .burst_type(burst_type), .cas_lat(cas_lat),
        .wb_single(wb_single), .ext_sel(ext_sel), .ext_val(ext_val),
        .busy(busy), .done(done), .err(err),
        .command(command), .addr(addr), .ba(ba)
    );

    scg_mrs #(.PRE_FIRST(1'b0), .T_MRD(1)) dut2 (
        .clk(clk), .n_rst(n_rst), .start(start2),
        .burst_len(burst_len), .burst_type(burst_type), .cas_lat(cas_lat),
        .wb_single(wb_single), .ext_sel(ext_sel), .ext_val(ext_val),
        .busy(busy2), .done(done2), .err(err2),
        .command(command2), .addr(addr2), .ba(ba2)
    );

    task automatic set_cfg(input logic [2:0] bl, input logic bt, input logic [2:0] cl,
                           input logic wb, input logic es, input logic [12:0] ev);
        burst_len  = bl;
        burst_type = bt;
        cas_lat    = cl;
        wb_single  = wb;
        ext_sel    = es;
        ext_val    = ev;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        n_rst = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        set_cfg(3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 13'h0);
        #1;
        obs = {busy, done, err, command};
        total++;
        if (obs !== 7'h00 || addr !== 13'h0 || ba !== 2'd0) begin
            bad++;
            $display("FAIL reset_state bdec=%h addr=%h ba=%h expected 00/0000/0", obs, addr, ba);
        end
        @(negedge clk);
        n_rst = 1'b1;

        // Reset during the PRE cycle must drop addr[10] immediately.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (command !== 4'd5 || addr !== 13'h400) begin
            bad++;
            $display("FAIL rst_pre_setup cmd=%0d addr=%h expected 5/0400", command, addr);
        end
        #1 n_rst = 1'b0;
        #1;
        total++;
        if ({busy, command} !== 5'h00 || addr !== 13'h0 || ba !== 2'd0) begin
            bad++;
            $display("FAIL rst_pre_async busy=%b cmd=%0d addr=%h ba=%0d expected 0/0/0000/0",
                     busy, command, addr, ba);
        end
        @(negedge clk);
        n_rst = 1'b1;

        // Reset mid-WAIT_RP: abort, no MRS afterwards.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        obs = {busy, done, err, command};
        total++;
        if (obs !== 7'h40) begin
            bad++;
            $display("FAIL rst_waitrp_setup bdec=%h expected 40", obs);
        end
        #1 n_rst = 1'b0;
        #1;
        obs = {busy, done, err, command};
        total++;
        if (obs !== 7'h00 || addr !== 13'h0) begin
            bad++;
            $display("FAIL rst_waitrp_async bdec=%h addr=%h expected 00/0000", obs, addr);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs = {busy, done, err, command};
            total++;
            if (obs !== 7'h00) begin
                bad++;
                $display("FAIL rst_no_resume cyc=%0d bdec=%h expected 00", i, obs);
            end
        end
    endtask

    task automatic test_mrs_default();
        logic [6:0]  obs, exp;
        logic [3:0]  ec;
        logic [12:0] ea;
        @(negedge clk);
        set_cfg(3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 13'h1fff);
        start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start = 1'b0;
            ec  = (i == 1) ? 4'd5 : (i == 4) ? 4'd7 : 4'd0;
            ea  = (i == 1) ? 13'h400 : (i == 4) ? 13'h033 : 13'h000;
            exp = {(i <= 6), (i == 6), 1'b0, ec};
            obs = {busy, done, err, command};
            total++;
            if (obs !== exp || addr !== ea || ba !== 2'd0) begin
                bad++;
                $display("FAIL default_seq cyc=%0d bdec=%h addr=%h ba=%0d expected %h/%h/0",
                         i, obs, addr, ba, exp, ea);
            end
        end
    endtask

    task automatic test_emrs_short();
        logic [6:0] obs;
        @(negedge clk);
        set_cfg(3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 13'h0002);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        obs = {busy2, done2, err2, command2};
        total++;
        if (obs !== 7'h47 || addr2 !== 13'h0002 || ba2 !== 2'd1) begin
            bad++;
            $display("FAIL emrs_cmd bdec=%h addr=%h ba=%0d expected 47/0002/1", obs, addr2, ba2);
        end
        @(negedge clk);
        obs = {busy2, done2, err2, command2};
        total++;
        if (obs !== 7'h60 || addr2 !== 13'h0 || ba2 !== 2'd0) begin
            bad++;
            $display("FAIL emrs_done bdec=%h addr=%h ba=%0d expected 60/0000/0", obs, addr2, ba2);
        end
        @(negedge clk);
        obs = {busy2, done2, err2, command2};
        total++;
        if (obs !== 7'h00) begin
            bad++;
            $display("FAIL emrs_idle bdec=%h expected 00", obs);
        end

        // Plain MRS on the same short instance, full-page burst.
        set_cfg(3'd7, 1'b1, 3'd2, 1'b1, 1'b0, 13'h0);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        obs = {busy2, done2, err2, command2};
        total++;
        if (obs !== 7'h47 || addr2 !== 13'h022f || ba2 !== 2'd0) begin
            bad++;
            $display("FAIL mrs_short bdec=%h addr=%h ba=%0d expected 47/022f/0", obs, addr2, ba2);
        end
        @(negedge clk);
        total++;
        if (done2 !== 1'b1 || err2 !== 1'b0) begin
            bad++;
            $display("FAIL mrs_short_done done=%b err=%b expected 1/0", done2, err2);
        end
    endtask

    task automatic test_err();
        logic [6:0] obs;
        logic [2:0] bl_v [2];
        logic [2:0] cl_v [2];
        bl_v[0] = 3'd3; cl_v[0] = 3'd1;
        bl_v[1] = 3'd4; cl_v[1] = 3'd3;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            set_cfg(bl_v[v], 1'b0, cl_v[v], 1'b0, 1'b0, 13'h0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            obs = {busy, done, err, command};
            total++;
            if (obs !== 7'h70 || addr !== 13'h0) begin
                bad++;
                $display("FAIL err_pulse v=%0d bdec=%h addr=%h expected 70/0000", v, obs, addr);
            end
            @(negedge clk);
            obs = {busy, done, err, command};
            total++;
            if (obs !== 7'h00) begin
                bad++;
                $display("FAIL err_after v=%0d bdec=%h expected 00", v, obs);
            end
        end
        // EMRS skips the legality check even with an illegal CAS latency.
        set_cfg(3'd3, 1'b0, 3'd1, 1'b0, 1'b1, 13'h0155);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (command !== 4'd5 || err !== 1'b0) begin
            bad++;
            $display("FAIL emrs_nocheck cmd=%0d err=%b expected 5/0", command, err);
        end
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            if (i == 4) begin
                total++;
                if (command !== 4'd7 || addr !== 13'h0155 || ba !== 2'd1) begin
                    bad++;
                    $display("FAIL emrs_long cmd=%0d addr=%h ba=%0d expected 7/0155/1",
                             command, addr, ba);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  obs, exp;
        logic [3:0]  ec;
        @(negedge clk);
        set_cfg(3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 13'h0);
        start = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            ec  = (j == 1 || j == 8) ? 4'd5 : (j == 4 || j == 11) ? 4'd7 : 4'd0;
            exp = {!(j == 7 || j >= 14), (j == 6 || j == 13), 1'b0, ec};
            obs = {busy, done, err, command};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL b2b_seq cyc=%0d bdec=%h expected %h", j, obs, exp);
            end
            if (j == 4) begin
                total++;
                if (addr !== 13'h033) begin
                    bad++;
                    $display("FAIL b2b_cfg_hold addr=%h expected 0033", addr);
                end
            end
            if (j == 11) begin
                total++;
                if (addr !== 13'h22a) begin
                    bad++;
                    $display("FAIL b2b_cfg_new addr=%h expected 022a", addr);
                end
            end
            if (j == 2) set_cfg(3'd2, 1'b1, 3'd2, 1'b1, 1'b0, 13'h0);
            if (j == 8) start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_mrs_default();
        test_emrs_short();
        test_err();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scg_mrs.md
# scg_mrs

Parametrised mode-register-set command sequence generator for the SDRAM controller. On a start pulse it captures a mode configuration and optionally issues PRECHARGE ALL with a tRP wait. It then issues one MRS or EMRS command with the encoded mode word and waits tMRD before signalling done. It sits beside the other scg_* sequence generators under the controller's main FSM, which muxes its command/addr/ba onto the SDRAM pins while busy is high.

## Interface
- ADDR_W, 13: SDRAM address bus width, ≥ 11.
- BA_W, 2: bank address width.
- T_RP, 3: PRECHARGE-to-next-command cycles, ≥ 1.
- T_MRD, 2: MRS-to-next-command cycles, ≥ 1.
- PRE_FIRST, 1: 1 = precede MRS with PRECHARGE ALL; 0 = MRS only.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin sequence; sampled only in IDLE.
- burst_len  in  3  mode A[2:0]; legal values 0,1,2,3,7.
- burst_type  in  1  mode A[3].
- cas_lat  in  3  mode A[6:4]; legal values 2,3.
- wb_single  in  1  mode A[9].
- ext_sel  in  1  1 = EMRS: ba=1, addr=ext_val, no legality check.
- ext_val  in  ADDR_W  extended mode word.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on illegal config.
- command  out  4  CMD_NOP=0, CMD_PRE=5, CMD_MRS=7.
- addr  out  ADDR_W  SDRAM address.
- ba  out  BA_W  bank address.

## Operation
- States: IDLE, PRE, WAIT_RP, MRS, WAIT_MRD, DONE, ERR.
- IDLE: start=1 latches all config inputs into registers. Config inputs are ignored at all other times.
- Next state after start:
  - ERR if ext_sel=0 and the config is illegal.
  - Otherwise PRE if PRE_FIRST=1.
  - Otherwise MRS.
- Start while busy is ignored and not queued.
- PRE: command=CMD_PRE, addr[10]=1, other addr bits 0, ba=0. Goes to WAIT_RP, or to MRS if T_RP=1.
- WAIT_RP: T_RP-1 cycles of CMD_NOP, then MRS.
- MRS: command=CMD_MRS, one cycle. Goes to WAIT_MRD, or to DONE if T_MRD=1.
  - ext_sel=0: ba=0; addr = {0…, wb_single, 2'b00, cas_lat, burst_type, burst_len}.
  - ext_sel=1: ba=1; addr=ext_val.
- WAIT_MRD: T_MRD-1 cycles of CMD_NOP, then DONE.
- DONE: command=CMD_NOP, done=1, then IDLE.
- ERR: command=CMD_NOP, done=1, err=1, then IDLE. No SDRAM command is issued.
- Outputs are Moore: decoded from state and latched config only.
- In IDLE/WAIT/DONE/ERR: command=CMD_NOP, addr=0, ba=0.

## Timing
- Reset (async, immediate): state IDLE, busy=0, done=0, err=0, command=CMD_NOP, addr=0, ba=0, config registers 0.
- Reset mid-sequence aborts the sequence immediately, with no further commands.
- start high before edge k: first command (PRE or MRS) is driven in the cycle after edge k.
- Sequence length in cycles, busy=1 throughout, including the DONE cycle:
  - PRE_FIRST=1: T_RP+T_MRD+1.
  - PRE_FIRST=0: T_MRD+1.
  - ERR path: 1.
- PRE-to-MRS spacing is exactly T_RP cycles.
- MRS to the controller's next command is ≥ T_MRD+1 cycles; the controller may issue it in the cycle after done.
- start may be re-asserted in the cycle after done, which is IDLE, with no dead cycle required.
- Wait counter: down-counter of width $clog2(max(T_RP,T_MRD)+1).
  - Loaded on the cycle that enters a WAIT state.
  - Exits on reaching 1.
  - Never wraps.

## Structure
- Shared package scg_pkg holds:
  - command constants CMD_NOP, CMD_PRE, CMD_MRS as a 4-bit enum, shared with all scg_* blocks;
  - mode-word bit-position constants;
  - the A10 precharge-all bit index.
- The state enum is local to the module.
- One sub-module: scg_wait_cnt.
  - Parametrised load-and-count-down timer.
  - Ports: clk, n_rst, load, load_val, expired.
  - Reusable by the other scg_* generators.

## Test plan
- Reset mid-WAIT_RP (T_RP=3, T_MRD=2, PRE_FIRST=1) → outputs return to NOP/0 asynchronously; the next start produces a full sequence.
- Default params, start with burst_len=3, burst_type=0, cas_lat=3, wb_single=0, ext_sel=0:
  - commands over 6 cycles are 5,0,0,7,0,0;
  - PRE cycle has addr=0x400, ba=0;
  - MRS cycle has addr=0x033, ba=0;
  - done=1 only in cycle 6; busy=1 for cycles 1-6.
- PRE_FIRST=0, T_MRD=1, ext_sel=1, ext_val=0x0002 → MRS with ba=1, addr=0x0002; done in the next cycle; total 2 cycles.
- cas_lat=1, ext_sel=0 → one cycle with done=1, err=1, command=0; no PRE or MRS issued.
- start held high continuously → back-to-back sequences with exactly one IDLE cycle between done and the next PRE; changing config inputs mid-sequence does not alter addr.
